// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, fetch FSM states, PC select codes.
// Also carries the opcode constants the fetch memory already uses.
package cpu_pkg;

    localparam int PC_W  = 8;
    localparam int IMM_W = 16;
    localparam int JT_W  = 26;

    localparam logic [5:0] ADDI  = 6'b001000;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] RTYPE = 6'b000000;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALTED
    } state_e;

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_HOLD,
        SEL_BRANCH,
        SEL_JUMP
    } pc_sel_e;

    // branch_pc + 1 + sext(offset), reduced mod 2^PC_W.
    // Zero-extending bpc is fine: only the low PC_W bits survive.
    function automatic logic [PC_W-1:0] branch_tgt(
        input logic [PC_W-1:0]  bpc,
        input logic [IMM_W-1:0] off
    );
        logic [IMM_W-1:0] sum;
        sum = IMM_W'(bpc) + IMM_W'(1) + off;
        return sum[PC_W-1:0];
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/fetch bundle between the PC sequencer and its neighbours.
// master drives redirect/stall controls, slave is the sequencer.
interface pc_sequencer_if
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) ();

    logic              stall;
    logic              halt;
    logic              jump;
    logic [JT_W-1:0]   jump_target;
    logic              branch_taken;
    logic [PC_W-1:0]   branch_pc;
    logic [IMM_W-1:0]  branch_offset;

    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_plus1;
    logic [PC_W-1:0]   if_pc;
    logic              if_valid;
    logic [CNT_W-1:0]  fetch_count;
    logic              halted;

    modport master (
        output stall, halt, jump, jump_target,
        output branch_taken, branch_pc, branch_offset,
        input  pc, pc_plus1, if_pc, if_valid,
        input  fetch_count, halted
    );

    modport slave (
        input  stall, halt, jump, jump_target,
        input  branch_taken, branch_pc, branch_offset,
        output pc, pc_plus1, if_pc, if_valid,
        output fetch_count, halted
    );

endinterface

// File: rtl/pc_sequencer_next_pc_calc.sv
// Next-PC priority mux: halt > jump > branch > stall > sequential.
// Pure combinational; the sequencer owns all state.
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [PC_W-1:0]  pc_i,
    input  logic             halt_i,
    input  logic             stall_i,
    input  logic             jump_i,
    input  logic [JT_W-1:0]  jump_target_i,
    input  logic             branch_taken_i,
    input  logic [PC_W-1:0]  branch_pc_i,
    input  logic [IMM_W-1:0] branch_offset_i,
    output logic [PC_W-1:0]  next_pc_o,
    output pc_sel_e          sel_o,
    output logic             redirect_o
);

    // Only the low PC_W bits of a J-type target address the memory.
    logic unused_jt;
    assign unused_jt = ^jump_target_i[JT_W-1:PC_W];

    // Several requests may be active at once; first match wins.
    always_comb begin
        sel_o     = SEL_SEQ;
        next_pc_o = pc_i + PC_W'(1);
        priority case (1'b1)
            halt_i: begin
                sel_o     = SEL_HOLD;
                next_pc_o = pc_i;
            end
            jump_i: begin
                sel_o     = SEL_JUMP;
                next_pc_o = jump_target_i[PC_W-1:0];
            end
            branch_taken_i: begin
                sel_o     = SEL_BRANCH;
                next_pc_o = branch_tgt(branch_pc_i,
                                       branch_offset_i);
            end
            stall_i: begin
                sel_o     = SEL_HOLD;
                next_pc_o = pc_i;
            end
            default: begin
                sel_o     = SEL_SEQ;
                next_pc_o = pc_i + PC_W'(1);
            end
        endcase
    end

    assign redirect_o = (sel_o == SEL_JUMP) ||
                        (sel_o == SEL_BRANCH);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencing in front of a 1-cycle memory.
// if_pc/if_valid line up with the memory's ins output.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic            clk,
    input  logic            rst,
    pc_sequencer_if.slave   bus
);

    localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  if_pc_q, if_pc_d;
    logic             if_valid_q, if_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halted_q, halted_d;

    logic [PC_W-1:0]  next_pc;
    pc_sel_e          sel;
    logic             redirect;
    logic             consume;

    next_pc_calc u_next_pc (
        .pc_i            (pc_q),
        .halt_i          (bus.halt),
        .stall_i         (bus.stall),
        .jump_i          (bus.jump),
        .jump_target_i   (bus.jump_target),
        .branch_taken_i  (bus.branch_taken),
        .branch_pc_i     (bus.branch_pc),
        .branch_offset_i (bus.branch_offset),
        .next_pc_o       (next_pc),
        .sel_o           (sel),
        .redirect_o      (redirect)
    );

    // Downstream takes the instruction on any unstalled valid edge.
    assign consume = if_valid_q && !bus.stall;

    // Next-state for the fetch FSM and its tracked fetch slot.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;
        cnt_d      = cnt_q;
        halted_d   = halted_q;
        unique case (state_q)
            ST_HALTED: begin
                if_valid_d = 1'b0;
            end
            default: begin
                if (bus.halt) begin
                    state_d    = ST_HALTED;
                    halted_d   = 1'b1;
                    if_valid_d = 1'b0;
                    cnt_d      = cnt_q + CNT_W'(consume);
                end else begin
                    state_d = ST_RUN;
                    cnt_d   = cnt_q + CNT_W'(consume);
                    if (sel != SEL_HOLD) begin
                        pc_d       = next_pc;
                        if_pc_d    = pc_q;
                        if_valid_d = !redirect;
                    end
                end
            end
        endcase
    end

    // State register; reset wins over everything, even HALTED.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RST_PC;
            if_pc_q    <= RST_PC;
            if_valid_q <= 1'b0;
            cnt_q      <= '0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
            cnt_q      <= cnt_d;
            halted_q   <= halted_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus1    = pc_q + PC_W'(1);
    assign bus.if_pc       = if_pc_q;
    assign bus.if_valid    = if_valid_q;
    assign bus.fetch_count = cnt_q;
    assign bus.halted      = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, then random
// stimulus against an arithmetic reference model.
module tb_pc_sequencer;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pc_sequencer_if #(.CNT_W(16)) bus ();

    pc_sequencer #(.RESET_PC(0), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        r, s, h, j, b;
        logic [25:0] jt;
        logic [7:0]  bpc;
        logic [15:0] boff;
        int          pc, ifpc, iv, cnt, hl;
    } vec_t;

    vec_t tbl[$];
    int   passed = 0;
    int   total  = 0;

    // reference model state
    int m_pc, m_ifpc, m_iv, m_cnt, m_h;

    function automatic vec_t mk(
        input int r, s, h, j, b, jt, bpc, boff,
        input int pc, ifpc, iv, cnt, hl
    );
        vec_t v;
        v.r = r[0]; v.s = s[0]; v.h = h[0];
        v.j = j[0]; v.b = b[0];
        v.jt = jt[25:0]; v.bpc = bpc[7:0];
        v.boff = boff[15:0];
        v.pc = pc; v.ifpc = ifpc; v.iv = iv;
        v.cnt = cnt; v.hl = hl;
        return v;
    endfunction

    task automatic chk(input string nm, input int act,
                       input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d",
                      nm, act, exp);
    endtask

    task automatic drive(input logic r, s, h, j, b,
                         input logic [25:0] jt,
                         input logic [7:0] bpc,
                         input logic [15:0] boff);
        rst               = r;
        bus.stall         = s;
        bus.halt          = h;
        bus.jump          = j;
        bus.branch_taken  = b;
        bus.jump_target   = jt;
        bus.branch_pc     = bpc;
        bus.branch_offset = boff;
        @(posedge clk);
        #1;
    endtask

    // Spec-level behaviour of one clock edge.
    task automatic model_step(input logic r, s, h, j, b,
                              input logic [25:0] jt,
                              input logic [7:0] bpc,
                              input logic [15:0] boff);
        int used;
        int t;
        used = (m_iv == 1 && !s) ? 1 : 0;
        if (r) begin
            m_pc = 0; m_ifpc = 0; m_iv = 0;
            m_cnt = 0; m_h = 0;
        end else if (m_h == 1) begin
            m_iv = 0;
        end else if (h) begin
            m_cnt = (m_cnt + used) % 65536;
            m_iv = 0;
            m_h = 1;
        end else if (j) begin
            m_cnt = (m_cnt + used) % 65536;
            m_ifpc = m_pc;
            m_pc = int'(jt) % 256;
            m_iv = 0;
        end else if (b) begin
            m_cnt = (m_cnt + used) % 65536;
            m_ifpc = m_pc;
            t = int'(bpc) + 1 + int'($signed(boff));
            m_pc = t & 255;
            m_iv = 0;
        end else if (!s) begin
            m_cnt = (m_cnt + used) % 65536;
            m_ifpc = m_pc;
            m_pc = (m_pc + 1) % 256;
            m_iv = 1;
        end
    endtask

    initial begin
        logic r, s, h, j, b;
        logic [25:0] jt;
        logic [7:0]  bpc;
        logic [15:0] boff;

        // reset + 5 idle
        tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 2,1,1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 3,2,1,2,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 4,3,1,3,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 5,4,1,4,0));
        // stall 3 cycles at pc=3
        tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 2,1,1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 3,2,1,2,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0, 3,2,1,2,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0, 3,2,1,2,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0, 3,2,1,2,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 4,3,1,3,0));
        // branch 10 + 1 - 4
        tbl.push_back(mk(0,0,0,0,1,0,10,'hFFFC, 7,4,0,4,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 8,7,1,4,0));
        // jump beats branch
        tbl.push_back(mk(0,0,0,1,1,'hC0,10,5, 'hC0,8,0,5,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 'hC1,'hC0,1,5,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 'hC2,'hC1,1,6,0));
        // wrap 254 -> 255 -> 0, branch 250 + 1 + 10
        tbl.push_back(mk(0,0,0,1,0,'hFE,0,0, 'hFE,'hC2,0,7,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 'hFF,'hFE,1,7,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,'hFF,1,8,0));
        tbl.push_back(mk(0,0,0,0,1,0,250,10, 5,0,0,9,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 6,5,1,9,0));
        // halt at pc=20 with stall and jump
        tbl.push_back(mk(0,0,0,1,0,20,0,0, 20,6,0,10,0));
        tbl.push_back(mk(0,1,1,1,0,'h33,0,0, 20,6,0,10,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 20,6,0,10,1));
        tbl.push_back(mk(0,1,0,1,1,'h40,3,3, 20,6,0,10,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,0,1,0,0));
        // halt counts the consumption on its entry edge
        tbl.push_back(mk(0,0,1,0,0,0,0,0, 1,0,0,1,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,0,0,1,1));

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].s, tbl[i].h, tbl[i].j,
                  tbl[i].b, tbl[i].jt, tbl[i].bpc,
                  tbl[i].boff);
            chk($sformatf("v%0d pc", i),
                int'(bus.pc), tbl[i].pc);
            chk($sformatf("v%0d if_pc", i),
                int'(bus.if_pc), tbl[i].ifpc);
            chk($sformatf("v%0d if_valid", i),
                int'(bus.if_valid), tbl[i].iv);
            chk($sformatf("v%0d fetch_count", i),
                int'(bus.fetch_count), tbl[i].cnt);
            chk($sformatf("v%0d halted", i),
                int'(bus.halted), tbl[i].hl);
        end

        // random phase
        m_pc = 0; m_ifpc = 0; m_iv = 0; m_cnt = 0; m_h = 0;
        for (int n = 0; n < 3000; n++) begin
            r    = (n == 0) || ($urandom_range(0, 79) == 0);
            s    = ($urandom_range(0, 3) == 0);
            h    = ($urandom_range(0, 59) == 0);
            j    = ($urandom_range(0, 9) == 0);
            b    = ($urandom_range(0, 7) == 0);
            jt   = 26'($urandom);
            bpc  = 8'($urandom);
            boff = 16'($urandom);
            drive(r, s, h, j, b, jt, bpc, boff);
            model_step(r, s, h, j, b, jt, bpc, boff);
            chk($sformatf("r%0d pc", n),
                int'(bus.pc), m_pc);
            chk($sformatf("r%0d pc_plus1", n),
                int'(bus.pc_plus1), (m_pc + 1) % 256);
            chk($sformatf("r%0d if_pc", n),
                int'(bus.if_pc), m_ifpc);
            chk($sformatf("r%0d if_valid", n),
                int'(bus.if_valid), m_iv);
            chk($sformatf("r%0d fetch_count", n),
                int'(bus.fetch_count), m_cnt);
            chk($sformatf("r%0d halted", n),
                int'(bus.halted), m_h);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
